// File: rtl/dm_pkg.sv
// dm_pkg: shared op/exception codes, FSM states and fault classification for dm_bank.
package dm_pkg;
   localparam logic [2:0] OP_W  = 3'd0;
   localparam logic [2:0] OP_H  = 3'd1;
   localparam logic [2:0] OP_B  = 3'd2;
   localparam logic [2:0] OP_HU = 3'd3;
   localparam logic [2:0] OP_BU = 3'd4;

   localparam logic [1:0] EXC_NONE  = 2'd0;
   localparam logic [1:0] EXC_ALIGN = 2'd1;
   localparam logic [1:0] EXC_RANGE = 2'd2;
   localparam logic [1:0] EXC_OP    = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} dm_state_e;

   // Priority: illegal op, then misalignment, then range.
   function automatic logic [1:0] dm_fault(input logic we, input logic [2:0] op,
                                           input logic [1:0] lane, input logic in_range);
      return (op > OP_BU || (we && op > OP_B)) ? EXC_OP :
             ((op == OP_W && lane != 2'b00) || ((op == OP_H || op == OP_HU) && lane[0])) ? EXC_ALIGN :
             !in_range ? EXC_RANGE : EXC_NONE;
   endfunction
endpackage

// File: rtl/dm_lane_mux.sv
// dm_lane_mux: byte-enable, store-merge and sign/zero-extended load extraction for one word.
module dm_lane_mux
   import dm_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] merged,
   output logic [31:0] load_data
);
   logic [31:0] wrep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be = op == OP_W ? 4'b1111 :
           op == OP_H ? 4'b0011 << {lane[1], 1'b0} :
           op == OP_B ? 4'b0001 << lane : 4'b0000;
      wrep = op == OP_W ? wdata : op == OP_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      merged = old_word;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old_word[8*i +: 8];
      byte_sel = old_word[8*lane +: 8];
      half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
      load_data = op == OP_W  ? old_word :
                  op == OP_H  ? {{16{half_sel[15]}}, half_sel} :
                  op == OP_B  ? {{24{byte_sel[7]}}, byte_sel} :
                  op == OP_HU ? {16'd0, half_sel} :
                  op == OP_BU ? {24'd0, byte_sel} : 32'd0;
   end
endmodule

// File: rtl/dm_bank.sv
// dm_bank: MEM-stage data memory with valid/ready requests, wait states,
// byte-lane stores, extended sub-word loads and fault reporting.
module dm_bank
   import dm_pkg::*;
#(
   parameter int DEPTH       = 3072,
   parameter int WAIT_CYCLES = 0,
   parameter int TRACE       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_exc
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

   logic [31:0] mem [DEPTH];
   dm_state_e   state;
   logic [CW-1:0] cnt;
   logic        we_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q, wdata_q, pc_q;
   logic        in_range;
   logic [AW-1:0] idx;
   logic [31:0] old_word, merged, load_data;
   logic [3:0]  be;
   logic [1:0]  exc_c;

   assign in_range  = {1'b0, addr_q} < LIMIT;
   assign idx       = addr_q[AW+1:2];
   assign old_word  = in_range ? mem[idx] : 32'd0;
   assign exc_c     = dm_fault(we_q, op_q, addr_q[1:0], in_range);
   assign req_ready = state == S_IDLE;

   dm_lane_mux u_lane (
      .op(op_q),
      .lane(addr_q[1:0]),
      .old_word(old_word),
      .wdata(wdata_q),
      .be(be),
      .merged(merged),
      .load_data(load_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_exc   <= EXC_NONE;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 32'd0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               we_q    <= req_we;
               op_q    <= req_op;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               pc_q    <= req_pc;
               cnt     <= CW'(WAIT_CYCLES);
               state   <= WAIT_CYCLES > 0 ? S_WAIT : S_EXEC;
            end
            S_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= S_EXEC;
            end
            S_EXEC: begin
               resp_exc   <= exc_c;
               resp_rdata <= (exc_c == EXC_NONE && !we_q) ? load_data : 32'd0;
               if (we_q && exc_c == EXC_NONE && |be)
                  mem[idx] <= merged;
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            default: begin
               resp_valid <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   if (TRACE != 0) begin : g_trace
      always_ff @(posedge clk)
         if (!reset && state == S_EXEC && we_q && exc_c == EXC_NONE)
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
   end
`endif
endmodule

// File: tb/tb_dm_bank.sv
// tb_dm_bank: two banks (0 and 3 wait states) checked every cycle against a byte-level transaction model.
module tb_dm_bank;
   localparam int DEPTH = 3072;

   logic        clk = 0, reset = 1;
   logic        req_valid [2], req_ready [2], req_we [2], resp_valid [2];
   logic [2:0]  req_op [2];
   logic [31:0] req_addr [2], req_wdata [2], req_pc [2], resp_rdata [2];
   logic [1:0]  resp_exc [2];

   int checks = 0, errors = 0;
   bit chk_on = 0;

   // model state
   logic [31:0] mm [2][DEPTH];
   bit          outst [2];
   int          cyc_m [2];
   logic [31:0] pend_rd [2], last_rd [2];
   logic [1:0]  pend_ex [2], last_ex [2];

   always #5 clk = ~clk;

   dm_bank #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .TRACE(1)) u0 (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_pc(req_pc[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_exc(resp_exc[0])
   );

   dm_bank #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .TRACE(1)) u1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_pc(req_pc[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_exc(resp_exc[1])
   );

   function automatic int wc(input int k);
      return k == 1 ? 3 : 0;
   endfunction

   task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, got, exp, $time);
      end
   endtask

   // Byte-addressed reference: size from op, alignment as addr modulo size.
   function automatic void model_do(input int k, input logic we, input logic [2:0] op,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic [1:0] ex);
      int n, p;
      logic [31:0] word, v;
      n = (op == 0) ? 4 : (op == 1 || op == 3) ? 2 : 1;
      rd = 0;
      if (op > 4 || (we && op > 2)) ex = 3;
      else if (addr % n != 0) ex = 1;
      else if (addr >= 4 * DEPTH) ex = 2;
      else ex = 0;
      if (ex != 0) return;
      p = addr % 4;
      word = mm[k][addr / 4];
      if (we) begin
         for (int j = 0; j < n; j++) word[8*(p+j) +: 8] = wd[8*j +: 8];
         mm[k][addr / 4] = word;
      end else begin
         v = 0;
         for (int j = 0; j < n; j++) v[8*j +: 8] = word[8*(p+j) +: 8];
         if ((op == 1 || op == 2) && v[8*n-1])
            for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
         rd = v;
      end
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            outst[k] = 0; cyc_m[k] = 0; last_rd[k] = 0; last_ex[k] = 0;
            for (int i = 0; i < DEPTH; i++) mm[k][i] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!outst[k]) begin
               if (req_valid[k]) begin
                  model_do(k, req_we[k], req_op[k], req_addr[k], req_wdata[k], pend_rd[k], pend_ex[k]);
                  outst[k] = 1; cyc_m[k] = 1;
               end
            end else begin
               cyc_m[k]++;
               if (cyc_m[k] == wc(k) + 3) begin
                  outst[k] = 0; last_rd[k] = pend_rd[k]; last_ex[k] = pend_ex[k];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic fin;
      if (chk_on)
         for (int k = 0; k < 2; k++) begin
            fin = outst[k] && cyc_m[k] >= wc(k) + 2;
            check("req_ready", k, 32'(req_ready[k]), 32'(!outst[k]));
            check("resp_valid", k, 32'(resp_valid[k]), 32'(outst[k] && cyc_m[k] == wc(k) + 2));
            check("resp_rdata", k, resp_rdata[k], fin ? pend_rd[k] : last_rd[k]);
            check("resp_exc", k, 32'(resp_exc[k]), 32'(fin ? pend_ex[k] : last_ex[k]));
         end
   end

   task automatic wait_idle(input int k);
      int g;
      @(posedge clk); #1;
      g = 0;
      while (outst[k] && g < 50) begin @(posedge clk); #1; g++; end
   endtask

   task automatic txn(input int k, input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] xrd, input logic [1:0] xex);
      int n;
      wait_idle(k);
      req_we[k] = we; req_op[k] = op; req_addr[k] = addr; req_wdata[k] = wd;
      req_pc[k] = $urandom; req_valid[k] = 1;
      @(posedge clk); #1;
      req_valid[k] = 0; req_addr[k] = $urandom; req_wdata[k] = $urandom;
      n = 1;
      @(negedge clk);
      while (!resp_valid[k] && n < 40) begin @(negedge clk); n++; end
      check("latency", k, 32'(n), 32'(wc(k) + 2));
      check("lit_rdata", k, resp_rdata[k], xrd);
      check("lit_exc", k, 32'(resp_exc[k]), 32'(xex));
   endtask

   initial begin
      int first, second, acc, rv;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 0; req_we[k] = 0; req_op[k] = 0;
         req_addr[k] = 0; req_wdata[k] = 0; req_pc[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_ready", 0, 32'(req_ready[0]), 1);
      check("reset_resp_valid", 1, 32'(resp_valid[1]), 0);
      check("reset_rdata", 0, resp_rdata[0], 0);
      reset = 0;
      chk_on = 1;

      // word, byte and half lanes on the zero-wait bank
      txn(0, 1, 3'd0, 32'h10, 32'h12345678, 32'h0, 2'd0);
      txn(0, 0, 3'd0, 32'h10, 32'h0, 32'h12345678, 2'd0);
      txn(0, 1, 3'd2, 32'h13, 32'h000000AB, 32'h0, 2'd0);
      txn(0, 0, 3'd2, 32'h13, 32'h0, 32'hFFFFFFAB, 2'd0);
      txn(0, 0, 3'd4, 32'h13, 32'h0, 32'h000000AB, 2'd0);
      txn(0, 0, 3'd1, 32'h12, 32'h0, 32'hFFFFAB34, 2'd0);
      txn(0, 0, 3'd3, 32'h12, 32'h0, 32'h0000AB34, 2'd0);
      txn(0, 0, 3'd0, 32'h10, 32'h0, 32'hAB345678, 2'd0);
      // faults leave memory untouched
      txn(0, 1, 3'd0, 32'h11, 32'hDEADBEEF, 32'h0, 2'd1);
      txn(0, 0, 3'd1, 32'h3001, 32'h0, 32'h0, 2'd1);
      txn(0, 0, 3'd0, 32'h3000, 32'h0, 32'h0, 2'd2);
      txn(0, 1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 2'd3);
      txn(0, 0, 3'd6, 32'h10, 32'h0, 32'h0, 2'd3);
      txn(0, 1, 3'd1, 32'h2FFE, 32'hCAFE, 32'h0, 2'd0);
      txn(0, 0, 3'd1, 32'h2FFE, 32'h0, 32'hFFFFCAFE, 2'd0);
      txn(0, 0, 3'd0, 32'h10, 32'h0, 32'hAB345678, 2'd0);
      // back-to-back stores into one word
      txn(0, 1, 3'd1, 32'h42, 32'h0000BEEF, 32'h0, 2'd0);
      txn(0, 1, 3'd2, 32'h40, 32'h00000011, 32'h0, 2'd0);
      txn(0, 0, 3'd0, 32'h40, 32'h0, 32'hBEEF0011, 2'd0);

      // wait-state bank
      txn(1, 1, 3'd0, 32'h10, 32'h12345678, 32'h0, 2'd0);
      txn(1, 0, 3'd2, 32'h11, 32'h0, 32'h00000056, 2'd0);

      // held req_valid is re-accepted only six cycles later
      wait_idle(1);
      req_we[1] = 0; req_op[1] = 3'd0; req_addr[1] = 32'h10; req_valid[1] = 1;
      first = -1; second = -1; acc = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (req_valid[1] && req_ready[1]) begin
            if (acc == 0) first = i; else if (acc == 1) second = i;
            acc++;
         end
      end
      req_valid[1] = 0;
      check("hold_gap", 1, 32'(second - first), 32'd6);

      // reset while the store sits in WAIT
      wait_idle(1);
      req_we[1] = 1; req_op[1] = 3'd0; req_addr[1] = 32'h20; req_wdata[1] = 32'hFFFFFFFF; req_valid[1] = 1;
      @(posedge clk); #1;
      req_valid[1] = 0;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      rv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid[1]) rv++;
      end
      check("abort_no_resp", 1, 32'(rv), 0);
      txn(1, 0, 3'd0, 32'h20, 32'h0, 32'h0, 2'd0);

      // random traffic on both banks, checked by the per-cycle comparator
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         reset = $urandom_range(0, 499) == 0;
         for (int k = 0; k < 2; k++) begin
            req_valid[k] = $urandom_range(0, 2) != 0;
            req_we[k] = $urandom_range(0, 1) == 1;
            req_op[k] = $urandom_range(0, 5) == 0 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rv = $urandom_range(0, 7);
            req_addr[k] = rv < 5 ? 32'($urandom_range(0, 127)) :
                          rv < 7 ? 32'(4 * DEPTH - 8 + $urandom_range(0, 15)) : 32'($urandom);
            req_wdata[k] = $urandom;
            req_pc[k] = $urandom;
         end
      end
      @(posedge clk); #1;
      reset = 0;
      req_valid[0] = 0; req_valid[1] = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_bank.md
# dm_bank

Parametrised data-memory bank for the pipelined MIPS core's MEM stage. It supersedes the single-cycle DM with:
- a valid/ready request interface and configurable wait-state latency;
- byte-lane stores and sign/zero-extended sub-word loads;
- alignment, range and opcode checking reported as an exception code;
- a write-trace `$display` per committed store for grading comparison.

## Interface
Parameters:
- `DEPTH`, 3072: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH-1.
- `WAIT_CYCLES`, 0: extra cycles between request acceptance and commit; range 0..15.
- `TRACE`, 1: when 1, print a trace line on every committed store.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bank can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_op`  in  3  access size/extension code (package encoding).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low 8/16/32 bits are used.
- `req_pc`  in  32  PC of the instruction, used for trace only.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_exc`  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal op.

## Operation
- Opcodes: OP_W=0, OP_H=1, OP_B=2, OP_HU=3, OP_BU=4; codes 5–7 are illegal.
- Stores accept only W, H and B. A store with HU or BU gives exc 3.
- Fault priority: illegal op (3) > misaligned (1) > out of range (2).
  - Misaligned: W with addr[1:0]≠0, or H/HU with addr[0]≠0.
  - Out of range: addr ≥ 4*DEPTH.
- A faulting request never writes memory and returns rdata 0.
- Word index = addr[31:2]. Byte lane = addr[1:0]; halfword lane = addr[1].
- Store byte enables:
  - W: 4'b1111.
  - H: 4'b0011 << (2*addr[1]).
  - B: 4'b0001 << addr[1:0].
  - Only enabled lanes change.
- Loads:
  - H and B sign-extend from bit 15 or bit 7 of the selected lane.
  - HU and BU zero-extend.
  - W returns the whole word.
- Trace, when TRACE=1 and a store commits: `"%d@%h: *%h <= %h"` with $time, pc, {addr[31:2],2'b00} and the full merged word after the write.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, otherwise to EXEC.
  - WAIT: decrement the counter; go to EXEC when counter==1.
  - EXEC: one cycle. Memory read/write and the fault check happen on the edge leaving EXEC, which registers resp_rdata and resp_exc. Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Reset:
  - All words cleared to 0, FSM to IDLE, counter 0.
  - resp_valid=0, resp_rdata=0, resp_exc=0. req_ready=1 from the first cycle after reset.
  - Reset during WAIT or EXEC aborts the request. No write occurs and no response is issued.
- req_* inputs are ignored outside IDLE. They need not be held stable after acceptance.

## Timing
- Request accepted at edge E (req_valid & req_ready).
- EXEC occupies cycle E+WAIT_CYCLES+1.
- resp_valid is high in cycle E+WAIT_CYCLES+2.
- req_ready is high again in cycle E+WAIT_CYCLES+3.
- Minimum request spacing is WAIT_CYCLES+3 cycles.
- A store is visible to any later accepted load. No read-during-write hazard exists, because only one request is in flight.
- resp_rdata and resp_exc hold their values until the next EXEC.

## Structure
- Shared package `dm_pkg`:
  - op codes OP_W..OP_BU;
  - exception codes EXC_NONE, EXC_ALIGN, EXC_RANGE, EXC_OP;
  - FSM state encoding.
- Sub-module `dm_lane_mux` (combinational):
  - inputs: op, addr[1:0], old word, wdata;
  - outputs: byte-enable, merged write word, extended load data.
  - Reused for both the write path and the trace value.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1.

## Test plan
- **Word store/load, WAIT_CYCLES=0.** Store W 0x12345678 @0x10, then load W @0x10.
  - Store resp_valid 2 cycles after accept.
  - Trace line `*00000010 <= 12345678`.
  - Load returns 0x12345678, exc 0.
- **Byte/half lanes.** Store B 0xAB @0x13, then load B @0x13, load BU @0x13, load H @0x12.
  - Word becomes 0xAB345678.
  - Load B returns 0xFFFFFFAB; load BU returns 0x000000AB; load H returns 0xFFFFAB34.
- **Faults.**
  - Store W @0x11: exc 1.
  - Load H @0x3001: exc 1.
  - Load W @0x3000 with DEPTH=3072: exc 2.
  - Store with op BU: exc 3.
  - Memory unchanged in all four cases; rdata 0.
- **Wait states, WAIT_CYCLES=3.**
  - req_ready low for 5 cycles after accept.
  - resp_valid in cycle E+5.
  - A req_valid held throughout is accepted only at E+6.
- **Reset mid-request.** Assert reset in WAIT during a store of 0xFFFFFFFF @0x20.
  - No resp_valid and no trace line.
  - A subsequent load @0x20 returns 0.
- **Back-to-back stores to one word.** Store H 0xBEEF @0x42, then store B 0x11 @0x40.
  - Word becomes 0xBEEF0011.
  - Trace shows the merged word each time.
